// File: rtl/dmem_responder.sv
// Memory-side responder for the M-stage load/store port: word/byte accesses
// with a fixed wait-state count, misalignment flagging and a stall to the pipeline.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic        byteM,
  input  logic [31:0] addrM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        misalignM
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic          req, is_load, mis, commit, we;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [7:0]    lane_byte;
  logic [31:0]   rd_word, load_val, wdata;
  logic [3:0]    wmask;
  logic          unused_addr_bits;

  assign req              = memreadM | memwriteM;
  assign is_load          = memreadM & ~memwriteM;  // store wins when both strobes are high
  assign mis              = ~byteM & (addrM[1:0] != 2'b00);
  assign idx              = addrM[AW+1:2];
  assign lane             = addrM[1:0];
  assign unused_addr_bits = ^addrM[31:AW+2];

  assign rd_word   = mem_q[idx];
  assign lane_byte = rd_word[8*lane +: 8];
  assign load_val  = mis   ? 32'd0 :
                     byteM ? {{24{lane_byte[7]}}, lane_byte} : rd_word;

  assign wdata = byteM ? {4{writedataM[7:0]}} : writedataM;
  assign wmask = byteM ? (4'b0001 << lane) : 4'b1111;
  assign we    = commit & memwriteM & ~mis & ~reset;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  generate
    if (LATENCY == 0) begin : g_comb
      assign commit    = req;
      assign stallM    = 1'b0;
      assign misalignM = req & mis;
      assign readdataM = is_load ? load_val : 32'd0;
    end else begin : g_fsm
      typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
      localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

      state_t      state_q, state_d;
      logic [3:0]  cnt_q, cnt_d;
      logic [31:0] rdata_q;
      logic        mis_q;

      always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;
        stallM    = 1'b0;
        readdataM = 32'd0;
        misalignM = 1'b0;
        case (state_q)
          IDLE: begin
            if (req) begin
              stallM = 1'b1;
              cnt_d  = CNT_INIT;
              if (LATENCY == 1) begin
                commit  = 1'b1;
                state_d = DONE;
              end else begin
                state_d = BUSY;
              end
            end
          end
          BUSY: begin
            stallM = 1'b1;
            cnt_d  = cnt_q - 4'd1;
            if (cnt_d == 4'd0) begin
              commit  = 1'b1;
              state_d = DONE;
            end
          end
          DONE: begin
            readdataM = rdata_q;
            misalignM = mis_q;
            state_d   = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end

      // The response is latched at the commit edge so DONE ignores the held inputs.
      always_ff @(posedge clk) begin
        if (reset) begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
          rdata_q <= 32'd0;
          mis_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          if (commit) begin
            rdata_q <= is_load ? load_val : 32'd0;
            mis_q   <= mis;
          end
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 0, 3) checked against a
// word-array reference model, a directed vector table and a reset-abort sequence.
module tb_dmem_responder;
  logic        clk;
  logic        rst [3];
  logic        mr  [3];
  logic        mw  [3];
  logic        bm  [3];
  logic [31:0] ad  [3];
  logic [31:0] wd  [3];
  logic [31:0] rdo [3];
  logic        st  [3];
  logic        mo  [3];

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [3][64];

  typedef struct {
    int          d;
    bit          rd, wr, byt;
    logic [31:0] addr, wdata, exp_r;
    bit          exp_m;
  } vec_t;
  vec_t tbl[$];

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(rst[0]), .memreadM(mr[0]), .memwriteM(mw[0]), .byteM(bm[0]),
    .addrM(ad[0]), .writedataM(wd[0]), .readdataM(rdo[0]), .stallM(st[0]), .misalignM(mo[0]));
  dmem_responder #(.DEPTH(64), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(rst[1]), .memreadM(mr[1]), .memwriteM(mw[1]), .byteM(bm[1]),
    .addrM(ad[1]), .writedataM(wd[1]), .readdataM(rdo[1]), .stallM(st[1]), .misalignM(mo[1]));
  dmem_responder #(.DEPTH(64), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(rst[2]), .memreadM(mr[2]), .memwriteM(mw[2]), .byteM(bm[2]),
    .addrM(ad[2]), .writedataM(wd[2]), .readdataM(rdo[2]), .stallM(st[2]), .misalignM(mo[2]));

  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 0 : 3;
  endfunction

  task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d got=%h want=%h", name, d, act, exp);
    end
  endtask

  // Reference: 64-word array, index = (addr/4) mod 64, lane = addr mod 4.
  task automatic model_step(input int d, input bit rd, input bit wr, input bit byt,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] er, output bit em);
    int          widx, ln;
    logic [31:0] old, b;
    widx = int'((addr / 4) % 64);
    ln   = int'(addr % 4);
    em   = !byt && ln != 0;
    old  = model[d][widx];
    er   = 32'd0;
    if (wr) begin
      if (!em) begin
        if (byt) old[ln*8 +: 8] = wdata[7:0];
        else     old = wdata;
        model[d][widx] = old;
      end
    end else if (rd && !em) begin
      if (byt) begin
        b  = (old >> (8 * ln)) & 32'hFF;
        er = (b >= 128) ? (b | 32'hFFFFFF00) : b;
      end else begin
        er = old;
      end
    end
  endtask

  // Called just after a rising edge; returns just after the edge ending the access.
  task automatic do_access(input int d, input bit rd, input bit wr, input bit byt,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] got, output bit got_m);
    logic [31:0] er;
    bit          em;
    model_step(d, rd, wr, byt, addr, wdata, er, em);
    mr[d] = rd; mw[d] = wr; bm[d] = byt; ad[d] = addr; wd[d] = wdata;
    for (int k = 0; k < lat_of(d); k++) begin
      @(negedge clk);
      check("stall_phase", d, {30'd0, st[d], mo[d], rdo[d]}, {30'd0, 1'b1, 1'b0, 32'd0});
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("done_stall", d, {63'd0, st[d]}, 64'd0);
    got   = rdo[d];
    got_m = mo[d];
    check("rdata", d, {32'd0, got}, {32'd0, er});
    check("misalign", d, {63'd0, got_m}, {63'd0, em});
    @(posedge clk); #1;
    mr[d] = 1'b0; mw[d] = 1'b0; bm[d] = 1'b0;
    $display("txn dut=%0d rd=%0b wr=%0b byte=%0b addr=%h wdata=%h rdata=%h mis=%0b",
             d, rd, wr, byt, addr, wdata, got, got_m);
  endtask

  task automatic idle(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("idle", d, {30'd0, st[d], mo[d], rdo[d]}, 64'd0);
      @(posedge clk); #1;
    end
  endtask

  function automatic vec_t mk(input int d, input bit rd, input bit wr, input bit byt,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_r, input bit exp_m);
    vec_t v;
    v.d = d; v.rd = rd; v.wr = wr; v.byt = byt;
    v.addr = addr; v.wdata = wdata; v.exp_r = exp_r; v.exp_m = exp_m;
    return v;
  endfunction

  initial begin
    logic [31:0] got, a;
    bit          gm, byt, rd, wr;
    int          d, kind;

    clk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; mr[i] = 1'b0; mw[i] = 1'b0; bm[i] = 1'b0; ad[i] = 32'd0; wd[i] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      check("reset_out", i, {30'd0, st[i], mo[i], rdo[i]}, 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    idle(0, 10);

    // Give every word a known value so the model is fully defined.
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 64; w++)
        do_access(i, 1'b0, 1'b1, 1'b0, 32'(w * 4), $urandom, got, gm);

    // Directed vectors: dut 0 is LATENCY=2, dut 1 is LATENCY=0.
    tbl.push_back(mk(0, 0, 1, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h20,  32'hCAFEF00D, 32'h0,        0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h22,  32'h12345678, 32'h0,        1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h20,  32'h0,        32'hCAFEF00D, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h22,  32'h0,        32'h0,        1));
    tbl.push_back(mk(0, 0, 1, 0, 32'h100, 32'hA5A5A5A5, 32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h000, 32'h0,        32'hA5A5A5A5, 0));
    tbl.push_back(mk(0, 1, 1, 0, 32'h30,  32'h00000077, 32'h0,        0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h30,  32'h0,        32'h00000077, 0));
    tbl.push_back(mk(1, 0, 1, 0, 32'h10,  32'h00000000, 32'h0,        0));
    tbl.push_back(mk(1, 0, 1, 1, 32'h11,  32'h12345680, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 1, 32'h11,  32'h0,        32'hFFFFFF80, 0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h10,  32'h0,        32'h00008000, 0));
    tbl.push_back(mk(1, 1, 0, 1, 32'h10,  32'h0,        32'h00000000, 0));
    tbl.push_back(mk(1, 0, 1, 1, 32'h13,  32'hFFFFFF7F, 32'h0,        0));
    tbl.push_back(mk(1, 1, 0, 1, 32'h13,  32'h0,        32'h0000007F, 0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h10,  32'h0,        32'h7F008000, 0));
    foreach (tbl[i]) begin
      do_access(tbl[i].d, tbl[i].rd, tbl[i].wr, tbl[i].byt, tbl[i].addr, tbl[i].wdata, got, gm);
      check("vec_rdata", tbl[i].d, {32'd0, got}, {32'd0, tbl[i].exp_r});
      check("vec_mis", tbl[i].d, {63'd0, gm}, {63'd0, tbl[i].exp_m});
    end
    idle(0, 2);

    // Reset in the second stall cycle of a LATENCY=3 store drops the store.
    do_access(2, 1'b0, 1'b1, 1'b0, 32'h8, 32'h22222222, got, gm);
    mw[2] = 1'b1; ad[2] = 32'h8; wd[2] = 32'h11111111;
    @(negedge clk);
    check("abort_stall1", 2, {63'd0, st[2]}, 64'd1);
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0; mw[2] = 1'b0;
    idle(2, 3);
    do_access(2, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, got, gm);
    check("abort_keep_old", 2, {32'd0, got}, {32'd0, 32'h22222222});

    // Random traffic, back-to-back with occasional idle gaps.
    for (int it = 0; it < 240; it++) begin
      d    = $urandom_range(0, 2);
      kind = $urandom_range(0, 3);
      rd   = (kind != 1);
      wr   = (kind == 1) || (kind == 2);
      byt  = $urandom_range(0, 1);
      a    = $urandom;
      if (!byt && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_access(d, rd, wr, byt, a, $urandom, got, gm);
      if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
